// File: rtl/svn_pkg.sv
// Shared types and constants for the 7-segment scan path.
package svn_pkg;

    localparam logic [7:0] AN_OFF   = 8'hFF;
    localparam int         N_DIGITS = 8;
    localparam int         NIB_W    = 4;

    // One displayable frame: nibbles, decimal points and per-digit enables.
    typedef struct packed {
        logic [N_DIGITS*NIB_W-1:0] data;
        logic [N_DIGITS-1:0]       dp_mask;
        logic [N_DIGITS-1:0]       en_mask;
    } frame_t;

    // Leading-zero blanking mask: digit i>0 is blanked when every enabled
    // digit from i upward carries a zero nibble and no DP. Digit 0 never blanks.
    function automatic logic [N_DIGITS-1:0] lzb_mask(input frame_t f);
        logic [N_DIGITS-1:0] m;
        logic                zero_above;
        m          = '0;
        zero_above = 1'b1;
        for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
            if (f.en_mask[i] && ((f.data[i*NIB_W +: NIB_W] != '0) || f.dp_mask[i]))
                zero_above = 1'b0;
            m[i] = zero_above;
        end
        return m;
    endfunction

endpackage

// File: rtl/svn_tick_gen.sv
// Digit-slot timebase: free-running counter 0..TICK_DIV-1 with terminal-count flag.
module svn_tick_gen #(
    parameter int unsigned  TICK_DIV = 100000,
    localparam int unsigned CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic [CW-1:0] slot_cnt,
    output logic          tc
);

    logic [CW-1:0] r_cnt;

    assign slot_cnt = r_cnt;
    assign tc       = (r_cnt == CW'(TICK_DIV - 1));

    // Slot counter with explicit wrap at terminal count.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (tc)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/svn_scan_mux.sv
// Time-multiplexed 8-digit scan controller with double-buffered frame,
// blank window per slot and optional leading-zero blanking.
module svn_scan_mux
    import svn_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 64,
    parameter bit          LZB       = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_DIGITS*NIB_W-1:0] data,
    input  logic [N_DIGITS-1:0]       dp_mask,
    input  logic [N_DIGITS-1:0]       en_mask,
    input  logic                      load,
    output logic [NIB_W-1:0]          digit,
    output logic                      dp_out,
    output logic [7:0]                AN,
    output logic                      frame_done
);

    localparam int unsigned CW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(N_DIGITS);

    logic [CW-1:0]       w_cnt;
    logic                w_tc;
    logic [CW-1:0]       w_cnt_nxt;
    logic                w_last;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_commit;
    frame_t              w_act_nxt;
    logic [N_DIGITS-1:0] w_lzb;
    logic                w_shown;
    logic [7:0]          w_an_nxt;

    logic [IDX_W-1:0]    r_idx;
    frame_t              r_active;
    frame_t              r_shadow;
    logic                r_pending;
    logic [NIB_W-1:0]    r_digit;
    logic                r_dp;
    logic [7:0]          r_an;
    logic                r_fdone;

    svn_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_cnt (w_cnt),
        .tc       (w_tc)
    );

    // Outputs are registered, so everything is computed for the state that
    // becomes current after this edge: next slot cycle, next index and the
    // frame that will be active (shadow if a boundary commit happens now).
    always_comb begin
        w_cnt_nxt = w_tc ? '0 : w_cnt + 1'b1;
        w_last    = (r_idx == IDX_W'(N_DIGITS - 1));
        w_idx_nxt = r_idx;
        if (w_tc)
            w_idx_nxt = w_last ? '0 : r_idx + 1'b1;
        w_commit  = w_tc && w_last && r_pending;
        w_act_nxt = w_commit ? r_shadow : r_active;
        w_lzb     = LZB ? lzb_mask(w_act_nxt) : '0;
        w_shown   = w_act_nxt.en_mask[w_idx_nxt] && !w_lzb[w_idx_nxt];
        w_an_nxt  = AN_OFF;
        if (w_cnt_nxt >= CW'(BLANK_CYC) && w_shown)
            w_an_nxt = ~(8'(1) << w_idx_nxt);
    end

    // Scan index, double buffer and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_digit   <= '0;
            r_dp      <= 1'b0;
            r_an      <= AN_OFF;
            r_fdone   <= 1'b0;
        end else begin
            r_idx    <= w_idx_nxt;
            r_active <= w_act_nxt;
            r_an     <= w_an_nxt;
            r_fdone  <= w_tc && w_last;
            if (w_tc) begin
                r_digit <= w_act_nxt.data[w_idx_nxt*NIB_W +: NIB_W];
                r_dp    <= w_act_nxt.dp_mask[w_idx_nxt];
            end
            // A load in the boundary cycle wins over the commit clearing pending.
            if (load) begin
                r_shadow  <= '{data: data, dp_mask: dp_mask, en_mask: en_mask};
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign digit      = r_digit;
    assign dp_out     = r_dp;
    assign AN         = r_an;
    assign frame_done = r_fdone;

endmodule

// File: tb/tb_svn_scan_mux.sv
// Self-checking bench for svn_scan_mux: directed scenarios plus random loads
// and resets, compared each cycle against a frame-position reference model.
module tb_svn_scan_mux;

    localparam int TD    = 4;
    localparam int BL    = 1;
    localparam int ND    = 8;
    localparam int FRAME = TD * ND;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data;
    logic [7:0]  dp_mask;
    logic [7:0]  en_mask;
    logic        load;

    logic [3:0]  dig0, dig1;
    logic        dp0, dp1, fd0, fd1;
    logic [7:0]  an0, an1;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int       k;
    logic [3:0] act_nib[ND];
    bit         act_dp[ND];
    bit         act_en[ND];
    logic [3:0] sh_nib[ND];
    bit         sh_dp[ND];
    bit         sh_en[ND];
    bit         pend;

    always #5 clk = ~clk;

    svn_scan_mux #(.TICK_DIV(TD), .BLANK_CYC(BL), .LZB(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .data(data), .dp_mask(dp_mask), .en_mask(en_mask),
        .load(load), .digit(dig0), .dp_out(dp0), .AN(an0), .frame_done(fd0)
    );

    svn_scan_mux #(.TICK_DIV(TD), .BLANK_CYC(BL), .LZB(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .data(data), .dp_mask(dp_mask), .en_mask(en_mask),
        .load(load), .digit(dig1), .dp_out(dp1), .AN(an1), .frame_done(fd1)
    );

    // Apply the effect of the coming clock edge to the model, using current inputs.
    task automatic model_edge();
        if (!rst_n) begin
            k    = 0;
            pend = 0;
            for (int i = 0; i < ND; i++) begin
                act_nib[i] = '0; act_dp[i] = 0; act_en[i] = 0;
                sh_nib[i]  = '0; sh_dp[i]  = 0; sh_en[i]  = 0;
            end
        end else begin
            k++;
            if ((k % FRAME) == 0 && pend) begin
                act_nib = sh_nib; act_dp = sh_dp; act_en = sh_en;
                pend = 0;
            end
            if (load) begin
                for (int i = 0; i < ND; i++) begin
                    sh_nib[i] = data[4*i +: 4];
                    sh_dp[i]  = dp_mask[i];
                    sh_en[i]  = en_mask[i];
                end
                pend = 1;
            end
        end
    endtask

    // Most significant enabled digit that carries a nonzero nibble or a DP.
    function automatic int msd();
        int m = 0;
        for (int j = 0; j < ND; j++)
            if (act_en[j] && (act_nib[j] != 0 || act_dp[j])) m = j;
        return m;
    endfunction

    function automatic logic [7:0] exp_an(input bit lzb);
        int p   = k % FRAME;
        int idx = p / TD;
        int c   = p % TD;
        bit shown = act_en[idx] && !(lzb && idx > msd());
        if (c < BL || !shown) return 8'hFF;
        return ~(8'h01 << idx);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h at model cycle %0d", tag, obs, expv, k);
        end
    endtask

    task automatic step();
        int idx;
        model_edge();
        @(posedge clk);
        #1;
        idx = (k % FRAME) / TD;
        chk("an_lzb0",  an0, exp_an(0));
        chk("an_lzb1",  an1, exp_an(1));
        chk("digit0",   {4'h0, dig0}, {4'h0, act_nib[idx]});
        chk("digit1",   {4'h0, dig1}, {4'h0, act_nib[idx]});
        chk("dp0",      {7'h0, dp0}, {7'h0, act_dp[idx]});
        chk("dp1",      {7'h0, dp1}, {7'h0, act_dp[idx]});
        chk("fdone0",   {7'h0, fd0}, {7'h0, (k > 0 && (k % FRAME) == 0)});
        chk("fdone1",   {7'h0, fd1}, {7'h0, (k > 0 && (k % FRAME) == 0)});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
        data = d; dp_mask = dp; en_mask = en; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) step();
    endtask

    initial begin
        rst_n = 1'b0; data = '0; dp_mask = '0; en_mask = '0; load = 1'b0;
        k = 0; pend = 0;

        // Reset held for five cycles, then an empty frame keeps AN dark
        run(5);
        rst_n = 1'b1;
        run(40);

        // Basic frame: digits 0..7 with DP on digit 0
        do_load(32'h76543210, 8'h01, 8'hFF);
        run(2 * FRAME);

        // Mid-frame load at idx 3 only takes effect at the next boundary
        run_to(3 * TD + 1);
        do_load(32'hAAAAAAAA, 8'h01, 8'hFF);
        run(2 * FRAME);

        // Upper four digits disabled
        do_load(32'h76543210, 8'h00, 8'h0F);
        run(2 * FRAME);

        // Leading-zero blanking cases
        do_load(32'h00000120, 8'h00, 8'hFF);
        run(2 * FRAME);
        do_load(32'h00000000, 8'h00, 8'hFF);
        run(2 * FRAME);
        do_load(32'h00000005, 8'h20, 8'hDF);
        run(2 * FRAME);

        // Load in the boundary cycle: copy uses the pre-write shadow
        do_load(32'h11111111, 8'h00, 8'hFF);
        run_to(FRAME - 1);
        do_load(32'h22222222, 8'hF0, 8'hFF);
        run(2 * FRAME);

        // Two loads in one frame: the last one wins
        do_load(32'h33333333, 8'h00, 8'hFF);
        run(3);
        do_load(32'h0000C0DE, 8'h0A, 8'h3C);
        run(2 * FRAME);

        // Single-cycle reset at idx 5 with a load pending
        run_to(5 * TD + 2);
        do_load(32'h99999999, 8'hFF, 8'hFF);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        run(FRAME + 8);

        // Random loads and occasional resets
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                data    = $urandom >> $urandom_range(0, 31);
                dp_mask = 8'($urandom & $urandom & $urandom);
                en_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
                load    = 1'b1;
            end
            step();
            load  = 1'b0;
            rst_n = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
